// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Size and state codes are fixed so the EX/MEM buffer and debug views agree on them.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Both 2'b10 and 2'b11 are treated as word accesses.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory bus: store replication and enables,
// load extraction and extension, and misalignment detection. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_lane,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misalign,
  input  logic [1:0]  i_ld_lane,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_signed,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata    = i_st_data;
    o_be       = 4'b1111;
    o_misalign = 1'b0;
    if (is_word(i_st_size)) begin
      o_misalign = (i_st_lane != 2'b00);
    end else if (i_st_size == SIZE_HALF) begin
      o_wdata    = {2{i_st_data[15:0]}};
      o_be       = i_st_lane[1] ? 4'b1100 : 4'b0011;
      o_misalign = i_st_lane[0];
    end else begin
      o_wdata    = {4{i_st_data[7:0]}};
      o_be       = 4'b0001 << i_st_lane;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (i_ld_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_rdata;
    if (i_ld_size == SIZE_HALF) begin
      o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
    end else if (i_ld_size == SIZE_BYTE) begin
      o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one req/ack bus transaction per load/store,
// holds the pipeline while it is in flight and aborts it after TIMEOUT cycles without ack.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] DataMemOut,
  output logic        MemStall,
  output logic        AlignErr,
  output logic        BusErr
);

  localparam logic [CNT_W-1:0] LP_TC = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_dout;
  logic              r_bus_err;
  logic              r_is_load;
  logic [1:0]        r_ld_lane;
  logic [1:0]        r_ld_size;
  logic              r_ld_signed;

  logic              w_access;
  logic              w_misalign;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic [31:0]       w_ld_data;

  assign w_access = MemRead | MemWrite;

  // Load extraction uses the lane/size captured at issue, not the live EX/MEM fields.
  mem_lane_align u_align (
    .i_st_lane   (ALUResult[1:0]),
    .i_st_size   (MemSize),
    .i_st_data   (WriteData),
    .o_wdata     (w_wdata),
    .o_be        (w_be),
    .o_misalign  (w_misalign),
    .i_ld_lane   (r_ld_lane),
    .i_ld_size   (r_ld_size),
    .i_ld_signed (r_ld_signed),
    .i_rdata     (bus_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_dout      <= '0;
      r_bus_err   <= 1'b0;
      r_is_load   <= 1'b0;
      r_ld_lane   <= '0;
      r_ld_size   <= '0;
      r_ld_signed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              r_dout <= '0;
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= MemWrite & ~MemRead;
              r_bus_addr  <= {ALUResult[31:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_be    <= w_be;
              r_is_load   <= MemRead;
              r_ld_lane   <= ALUResult[1:0];
              r_ld_size   <= MemSize;
              r_ld_signed <= MemSigned;
              r_cnt       <= '0;
              r_state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus_ack) begin
            r_dout    <= r_is_load ? w_ld_data : 32'h0;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_cnt == LP_TC) begin
            r_dout    <= '0;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The hold drops with reset so a squashed access never stalls the pipeline.
  always_comb begin
    MemStall = 1'b0;
    AlignErr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        MemStall = w_access & ~w_misalign;
        AlignErr = w_access & w_misalign;
      end
      ST_ACCESS: MemStall = 1'b1;
      default:   MemStall = 1'b0;
    endcase
    MemStall = MemStall & ~Reset;
  end

  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_be     = r_bus_be;
  assign DataMemOut = r_dout;
  assign BusErr     = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected load results are queued at issue
// and popped in the DONE cycle; bus fields and stall lengths are checked per access.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResult, WriteData, bus_rdata;
  logic        MemRead, MemWrite, MemSigned, bus_ack;
  logic [1:0]  MemSize;
  logic        bus_req, bus_we, MemStall, AlignErr, BusErr;
  logic [31:0] bus_addr, bus_wdata, DataMemOut;
  logic [3:0]  bus_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q_dout[$];

  mem_access_unit #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .DataMemOut(DataMemOut),
    .MemStall(MemStall), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Called just after a rising edge with the unit in IDLE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_at,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                            input logic [3:0] exp_be, input logic exp_we,
                            input logic [31:0] exp_dout, input logic exp_berr,
                            input int exp_stall);
    int stall;
    int cyc;
    logic [31:0] exp_q;
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn;
    ALUResult = addr; WriteData = wd; bus_rdata = rdata; bus_ack = 1'b0;
    q_dout.push_back(exp_dout);
    @(negedge Clk);
    chk({tag, ":align_idle"}, 32'(AlignErr), 32'd0);
    stall = (MemStall === 1'b1) ? 1 : 0;
    next_cycle();
    chk({tag, ":req"}, 32'(bus_req), 32'd1);
    chk({tag, ":we"}, 32'(bus_we), 32'(exp_we));
    chk({tag, ":addr"}, bus_addr, exp_addr);
    chk({tag, ":be"}, 32'(bus_be), 32'(exp_be));
    if (exp_we) chk({tag, ":wdata"}, bus_wdata, exp_wd);
    cyc = 1;
    while (bus_req === 1'b1 && cyc <= 300) begin
      bus_ack = (cyc == ack_at);
      @(negedge Clk);
      if (MemStall === 1'b1) stall++;
      next_cycle();
      cyc++;
    end
    bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    chk({tag, ":req_dropped"}, 32'(bus_req), 32'd0);
    chk({tag, ":access_cycles"}, 32'(cyc - 1), 32'(exp_stall - 1));
    @(negedge Clk);
    chk({tag, ":stall_done"}, 32'(MemStall), 32'd0);
    chk({tag, ":stall_len"}, 32'(stall), 32'(exp_stall));
    chk({tag, ":buserr_done"}, 32'(BusErr), 32'(exp_berr));
    exp_q = (q_dout.size() > 0) ? q_dout.pop_front() : 32'hxxxx_xxxx;
    chk({tag, ":dout"}, DataMemOut, exp_q);
    next_cycle();
    chk({tag, ":buserr_idle"}, 32'(BusErr), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
    ALUResult = '0; WriteData = '0; bus_rdata = '0; bus_ack = 1'b0;
    #2;
    chk("rst:req", 32'(bus_req), 32'd0);
    chk("rst:be", 32'(bus_be), 32'd0);
    chk("rst:addr", bus_addr, 32'd0);
    chk("rst:dout", DataMemOut, 32'd0);
    chk("rst:buserr", 32'(BusErr), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    next_cycle();

    // Stray ack with no access must not start anything.
    bus_ack = 1'b1;
    next_cycle();
    next_cycle();
    chk("idle_ack:req", 32'(bus_req), 32'd0);
    chk("idle_ack:stall", 32'(MemStall), 32'd0);
    bus_ack = 1'b0;

    run_access("ld_word", 1, 0, 2'b10, 0, 32'h10, 0, 32'h1234_5678, 1,
               32'h10, 0, 4'b1111, 0, 32'h1234_5678, 0, 2);
    run_access("ld_byte_s", 1, 0, 2'b00, 1, 32'h13, 0, 32'h80FF_0000, 1,
               32'h10, 0, 4'b1000, 0, 32'hFFFF_FF80, 0, 2);
    run_access("ld_byte_u", 1, 0, 2'b00, 0, 32'h13, 0, 32'h80FF_0000, 1,
               32'h10, 0, 4'b1000, 0, 32'h0000_0080, 0, 2);

    // Misaligned word load: flagged, no bus request, result cleared.
    MemRead = 1'b1; MemSize = 2'b10; ALUResult = 32'h06;
    q_dout.push_back(32'h0);
    @(negedge Clk);
    chk("misalign:align", 32'(AlignErr), 32'd1);
    chk("misalign:stall", 32'(MemStall), 32'd0);
    next_cycle();
    MemRead = 1'b0;
    chk("misalign:req", 32'(bus_req), 32'd0);
    chk("misalign:dout", DataMemOut, q_dout.pop_front());

    run_access("st_half", 0, 1, 2'b01, 0, 32'h22, 32'h0000_ABCD, 0, 3,
               32'h20, 32'hABCD_ABCD, 4'b1100, 1, 32'h0, 0, 4);
    run_access("ld_half_s", 1, 0, 2'b01, 1, 32'h2A, 0, 32'h8001_7FFF, 2,
               32'h28, 0, 4'b1100, 0, 32'hFFFF_8001, 0, 3);
    run_access("timeout", 1, 0, 2'b10, 0, 32'h44, 0, 32'h5555_5555, 0,
               32'h44, 0, 4'b1111, 0, 32'h0, 1, 17);
    run_access("st_byte", 0, 1, 2'b00, 0, 32'h41, 32'h1234_56AB, 0, 2,
               32'h40, 32'hABAB_ABAB, 4'b0010, 1, 32'h0, 0, 3);
    run_access("rd_wins", 1, 1, 2'b11, 0, 32'h100, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1,
               32'h100, 0, 4'b1111, 0, 32'hCAFE_F00D, 0, 2);
    run_access("ld_half_u", 1, 0, 2'b01, 0, 32'h02, 0, 32'h9ABC_1234, 1,
               32'h00, 0, 4'b1100, 0, 32'h0000_9ABC, 0, 2);

    // Reset in the second ACCESS cycle of a store.
    MemWrite = 1'b1; MemSize = 2'b01; ALUResult = 32'h22; WriteData = 32'h0000_1111;
    next_cycle();
    chk("rst_mid:req_before", 32'(bus_req), 32'd1);
    next_cycle();
    Reset = 1'b1;
    #1;
    chk("rst_mid:req", 32'(bus_req), 32'd0);
    chk("rst_mid:we", 32'(bus_we), 32'd0);
    chk("rst_mid:stall", 32'(MemStall), 32'd0);
    MemWrite = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    next_cycle();
    chk("rst_mid:idle_req", 32'(bus_req), 32'd0);
    run_access("post_rst_ld", 1, 0, 2'b10, 0, 32'h80, 0, 32'h0BAD_CAFE, 1,
               32'h80, 0, 4'b1111, 0, 32'h0BAD_CAFE, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
